// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
//
// Clocked burst front end for the on-chip SRAM model. A command is taken over a
// valid/ready handshake and then played out beat by beat. The SRAM word address
// advances by DATA_WORDS per beat and wraps modulo 2^ADDR_BITS.
//
//   Writes : one wr_valid/wr_ready handshake per beat, then a one-cycle
//            sram_write_enable pulse.
//   Reads  : sram_read_enable is held for READ_LAT cycles. The beat is then
//            captured into rd_data and held until rd_ready.
//   Dumps  : a one-cycle sram_mem_dump pulse with the latched dump number.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cmd_valid/_ready   command handshake; cmd_ready = controller in IDLE
//   cmd_write          1 = write burst, 0 = read burst
//   cmd_addr           word address of the first beat
//   cmd_len            beats minus one
//   wr_valid/_ready    write beat handshake; wr_ready = controller in WRITE
//   wr_data            write beat data
//   rd_valid/_ready    read beat handshake; rd_valid is registered
//   rd_data            read beat data, stable while rd_valid && !rd_ready
//   dump_req, dump_num memory dump request and file number
//   busy               controller not in IDLE
//   done               one-cycle pulse after the last beat of a burst
//   sram_*             registered drive of the SRAM model, plus its read data
// -----------------------------------------------------------------------------
module sram_burst_ctrl #(
    parameter int ADDR_BITS  = 16,
    parameter int WORD_BYTES = 1,
    parameter int DATA_WORDS = 16,
    parameter int LEN_BITS   = 4,
    parameter int READ_LAT   = 1,
    localparam int DW        = DATA_WORDS * WORD_BYTES * 8
) (
    input  logic                 clk,
    input  logic                 rst,
    // command channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]  cmd_len,
    // write data channel
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DW-1:0]        wr_data,
    // read data channel
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DW-1:0]        rd_data,
    // dump request
    input  logic                 dump_req,
    input  logic                 dump_num,
    // status
    output logic                 busy,
    output logic                 done,
    // SRAM side
    output logic                 sram_read_enable,
    output logic                 sram_write_enable,
    output logic [ADDR_BITS-1:0] sram_address,
    output logic [DW-1:0]        sram_write_data,
    input  logic [DW-1:0]        sram_read_data,
    output logic                 sram_mem_dump,
    output logic                 sram_dump_num
);

    // READ_LAT-1 has to fit in the latency counter; keep at least one bit
    // so that READ_LAT == 1 still gives a legal vector.
    localparam int LAT_BITS = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_BITS-1:0]  LAT_INIT = LAT_BITS'(READ_LAT - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_INC = ADDR_BITS'(DATA_WORDS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_WR_PULSE = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_HOLD  = 3'd5,
        S_DUMP     = 3'd6
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_BITS-1:0]  addr_q,      addr_d;       // address of the current beat
    logic [LEN_BITS-1:0]   cnt_q,       cnt_d;        // beats remaining after this one
    logic [LAT_BITS-1:0]   lat_q,       lat_d;        // read latency countdown
    logic                  rd_valid_q,  rd_valid_d;
    logic [DW-1:0]         rd_data_q,   rd_data_d;
    logic                  done_q,      done_d;
    logic                  re_q,        re_d;
    logic                  we_q,        we_d;
    logic [ADDR_BITS-1:0]  sram_addr_q, sram_addr_d;
    logic [DW-1:0]         wdata_q,     wdata_d;
    logic                  dump_q,      dump_d;
    logic                  dump_num_q,  dump_num_d;

    // Handshake readiness and busy come straight from the state.
    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);

    assign rd_valid          = rd_valid_q;
    assign rd_data           = rd_data_q;
    assign done              = done_q;
    assign sram_read_enable  = re_q;
    assign sram_write_enable = we_q;
    assign sram_address      = sram_addr_q;
    assign sram_write_data   = wdata_q;
    assign sram_mem_dump     = dump_q;
    assign sram_dump_num     = dump_num_q;

    // Next-state and registered-output logic for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        re_d        = re_q;
        we_d        = 1'b0;        // the write strobe is a single-cycle pulse
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        dump_d      = 1'b0;        // the dump strobe is a single-cycle pulse
        dump_num_d  = dump_num_q;

        case (state_q)
            S_IDLE: begin
                // A dump wins over a command offered in the same cycle.
                if (dump_req) begin
                    dump_num_d = dump_num;
                    dump_d     = 1'b1;
                    state_d    = S_DUMP;
                end else if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_DUMP: begin
                // sram_mem_dump is high during this state only.
                state_d = S_IDLE;
            end

            S_WRITE: begin
                if (wr_valid) begin
                    wdata_d     = wr_data;
                    sram_addr_d = addr_q;
                    we_d        = 1'b1;
                    state_d     = S_WR_PULSE;
                end else begin
                    state_d = S_WRITE;
                end
            end

            S_WR_PULSE: begin
                // The write strobe is high during this state; set up the next beat.
                if (cnt_q == {LEN_BITS{1'b0}}) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - LEN_BITS'(1);
                    addr_d  = addr_q + ADDR_INC;
                    state_d = S_WRITE;
                end
            end

            S_RD_ISSUE: begin
                sram_addr_d = addr_q;
                re_d        = 1'b1;
                lat_d       = LAT_INIT;
                state_d     = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                // The enable has been high for READ_LAT cycles when lat_q hits 0.
                if (lat_q == {LAT_BITS{1'b0}}) begin
                    rd_data_d  = sram_read_data;
                    rd_valid_d = 1'b1;
                    re_d       = 1'b0;
                    state_d    = S_RD_HOLD;
                end else begin
                    lat_d = lat_q - LAT_BITS'(1);
                end
            end

            S_RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (cnt_q == {LEN_BITS{1'b0}}) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q - LEN_BITS'(1);
                        addr_d  = addr_q + ADDR_INC;
                        state_d = S_RD_ISSUE;
                    end
                end else begin
                    state_d = S_RD_HOLD;
                end
            end

            default: begin
                // Unreachable encoding: park safely with the SRAM quiet.
                state_d    = S_IDLE;
                re_d       = 1'b0;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= {ADDR_BITS{1'b0}};
            cnt_q       <= {LEN_BITS{1'b0}};
            lat_q       <= {LAT_BITS{1'b0}};
            rd_valid_q  <= 1'b0;
            rd_data_q   <= {DW{1'b0}};
            done_q      <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            sram_addr_q <= {ADDR_BITS{1'b0}};
            wdata_q     <= {DW{1'b0}};
            dump_q      <= 1'b0;
            dump_num_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            re_q        <= re_d;
            we_q        <= we_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            dump_q      <= dump_d;
            dump_num_q  <= dump_num_d;
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_ctrl
//
// Directed bench for sram_burst_ctrl with READ_LAT = 2. The SRAM stand-in
// registers {8{address}} on every enabled read, so the expected read beat for
// any address can be written down by hand. Writes, read issues, done pulses and
// dump pulses are logged on the clock edge so that the bench can count them.
// -----------------------------------------------------------------------------
module tb_sram_burst_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_write = 1'b0;
    logic [15:0]  cmd_addr = 16'h0000;
    logic [3:0]   cmd_len = 4'h0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [127:0] wr_data = 128'h0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [127:0] rd_data;
    logic         dump_req = 1'b0;
    logic         dump_num = 1'b0;
    logic         busy;
    logic         done;
    logic         sram_read_enable;
    logic         sram_write_enable;
    logic [15:0]  sram_address;
    logic [127:0] sram_write_data;
    logic [127:0] sram_read_data = 128'h0;
    logic         sram_mem_dump;
    logic         sram_dump_num;

    int errors = 0;
    int checks = 0;

    logic [15:0]  wr_addr_log[$];
    logic [127:0] wr_data_log[$];
    logic [15:0]  rd_addr_log[$];
    int           done_cnt = 0;
    int           dump_cnt = 0;
    int           both_err = 0;
    logic         re_prev  = 1'b0;

    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2 = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;

    sram_burst_ctrl #(
        .ADDR_BITS (16),
        .WORD_BYTES(1),
        .DATA_WORDS(16),
        .LEN_BITS  (4),
        .READ_LAT  (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .dump_req         (dump_req),
        .dump_num         (dump_num),
        .busy             (busy),
        .done             (done),
        .sram_read_enable (sram_read_enable),
        .sram_write_enable(sram_write_enable),
        .sram_address     (sram_address),
        .sram_write_data  (sram_write_data),
        .sram_read_data   (sram_read_data),
        .sram_mem_dump    (sram_mem_dump),
        .sram_dump_num    (sram_dump_num)
    );

    always #5 clk = ~clk;

    // SRAM stand-in: registered read returning the address replicated.
    always @(posedge clk) begin
        if (sram_read_enable) begin
            sram_read_data <= {8{sram_address}};
        end
    end

    // Event logger sampling the controller's registered outputs at the edge.
    always @(posedge clk) begin
        if (sram_write_enable) begin
            wr_addr_log.push_back(sram_address);
            wr_data_log.push_back(sram_write_data);
        end
        if (sram_read_enable && !re_prev) begin
            rd_addr_log.push_back(sram_address);
        end
        if (sram_read_enable && sram_write_enable) begin
            both_err = both_err + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
        end
        if (sram_mem_dump) begin
            dump_cnt = dump_cnt + 1;
        end
        re_prev = sram_read_enable;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer a command for one edge; the caller makes sure the DUT is in IDLE.
    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        next_cycle();
        cmd_valid = 1'b0;
    endtask

    // Wait for exactly one done pulse, then confirm no further pulse follows.
    task automatic wait_done(input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 100) begin
            next_cycle();
            n++;
        end
        repeat (2) next_cycle();
        check_eq(tag, 128'(done_cnt - start), 128'd1);
        check_eq({tag, "_idle"}, {127'd0, cmd_ready}, 128'd1);
    endtask

    // Consume one read beat, optionally stalling rd_ready for some cycles.
    task automatic read_beat(input logic [15:0] exp_addr, input int stall);
        int n;
        n = 0;
        while (!rd_valid && n < 40) begin
            next_cycle();
            n++;
        end
        check_eq("rd_valid_seen", {127'd0, rd_valid}, 128'd1);
        check_eq("rd_data", rd_data, {8{exp_addr}});
        repeat (stall) next_cycle();
        if (stall > 0) begin
            check_eq("rd_stall_valid", {127'd0, rd_valid}, 128'd1);
            check_eq("rd_stall_data", rd_data, {8{exp_addr}});
        end
        rd_ready = 1'b1;
        next_cycle();
        rd_ready = 1'b0;
        check_eq("rd_valid_drop", {127'd0, rd_valid}, 128'd0);
    endtask

    initial begin
        int n;
        int rd_n;

        // Reset and idle state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        check_eq("rst_busy", {127'd0, busy}, 128'd0);
        check_eq("rst_re", {127'd0, sram_read_enable}, 128'd0);
        check_eq("rst_we", {127'd0, sram_write_enable}, 128'd0);
        check_eq("rst_dump", {127'd0, sram_mem_dump}, 128'd0);
        check_eq("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
        check_eq("rst_done", {127'd0, done}, 128'd0);

        // Single-beat write at 0x0010.
        wr_valid = 1'b1;
        wr_data  = D1;
        send_cmd(1'b1, 16'h0010, 4'd0);
        wait_done("wr1_done");
        wr_valid = 1'b0;
        check_eq("wr1_count", 128'(wr_addr_log.size()), 128'd1);
        if (wr_addr_log.size() >= 1) begin
            check_eq("wr1_addr", {112'd0, wr_addr_log[0]}, 128'h0010);
            check_eq("wr1_data", wr_data_log[0], D1);
        end

        // Four-beat read at 0x0010, second beat stalled for five cycles.
        send_cmd(1'b0, 16'h0010, 4'd3);
        n = 0;
        while (!rd_valid && n < 20) begin
            next_cycle();
            n++;
        end
        check_eq("rd_latency", 128'(n), 128'd3);
        read_beat(16'h0010, 0);
        read_beat(16'h0020, 5);
        read_beat(16'h0030, 0);
        read_beat(16'h0040, 0);
        wait_done("rd_burst_done");
        check_eq("rd_burst_count", 128'(rd_addr_log.size()), 128'd4);
        if (rd_addr_log.size() >= 4) begin
            check_eq("rd_addr0", {112'd0, rd_addr_log[0]}, 128'h0010);
            check_eq("rd_addr1", {112'd0, rd_addr_log[1]}, 128'h0020);
            check_eq("rd_addr2", {112'd0, rd_addr_log[2]}, 128'h0030);
            check_eq("rd_addr3", {112'd0, rd_addr_log[3]}, 128'h0040);
        end

        // Two-beat write crossing the top of memory.
        wr_valid = 1'b1;
        wr_data  = D2;
        send_cmd(1'b1, 16'hFFF0, 4'd1);
        wait_done("wrap_done");
        wr_valid = 1'b0;
        check_eq("wrap_count", 128'(wr_addr_log.size()), 128'd3);
        if (wr_addr_log.size() >= 3) begin
            check_eq("wrap_addr0", {112'd0, wr_addr_log[1]}, 128'hFFF0);
            check_eq("wrap_addr1", {112'd0, wr_addr_log[2]}, 128'h0000);
            check_eq("wrap_data1", wr_data_log[2], D2);
        end

        // Dump and command together; the command stays offered afterwards.
        dump_req  = 1'b1;
        dump_num  = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0050;
        cmd_len   = 4'd0;
        #1;
        check_eq("dump_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        next_cycle();
        dump_req = 1'b0;
        check_eq("dump_pulse", {127'd0, sram_mem_dump}, 128'd1);
        check_eq("dump_num", {127'd0, sram_dump_num}, 128'd1);
        check_eq("dump_busy", {127'd0, busy}, 128'd1);
        next_cycle();
        check_eq("dump_end", {127'd0, sram_mem_dump}, 128'd0);
        check_eq("dump_num_hold", {127'd0, sram_dump_num}, 128'd1);
        next_cycle();
        cmd_valid = 1'b0;
        check_eq("dump_cmd_later", {127'd0, busy}, 128'd1);
        read_beat(16'h0050, 0);
        wait_done("dump_rd_done");
        check_eq("dump_cnt1", 128'(dump_cnt), 128'd1);
        check_eq("dump_rd_count", 128'(rd_addr_log.size()), 128'd5);
        if (rd_addr_log.size() >= 5) begin
            check_eq("dump_rd_addr", {112'd0, rd_addr_log[4]}, 128'h0050);
        end

        // Dump with the command withdrawn: no command must be taken.
        rd_n      = rd_addr_log.size();
        dump_req  = 1'b1;
        dump_num  = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0060;
        next_cycle();
        dump_req  = 1'b0;
        cmd_valid = 1'b0;
        check_eq("dump2_num", {127'd0, sram_dump_num}, 128'd0);
        repeat (4) next_cycle();
        check_eq("dump2_busy", {127'd0, busy}, 128'd0);
        check_eq("dump2_no_cmd", 128'(rd_addr_log.size()), 128'(rd_n));
        check_eq("dump_cnt2", 128'(dump_cnt), 128'd2);

        // Reset asserted while the read enable is held.
        send_cmd(1'b0, 16'h0100, 4'd3);
        next_cycle();
        check_eq("mid_re_high", {127'd0, sram_read_enable}, 128'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_re", {127'd0, sram_read_enable}, 128'd0);
        check_eq("arst_busy", {127'd0, busy}, 128'd0);
        check_eq("arst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        check_eq("arst_rd_valid", {127'd0, rd_valid}, 128'd0);
        check_eq("arst_addr", {112'd0, sram_address}, 128'h0000);
        next_cycle();
        rst = 1'b0;
        send_cmd(1'b0, 16'h0200, 4'd0);
        read_beat(16'h0200, 0);
        wait_done("post_rst_done");
        if (rd_addr_log.size() >= 1) begin
            check_eq("post_rst_addr", {112'd0, rd_addr_log[rd_addr_log.size()-1]}, 128'h0200);
        end

        check_eq("enables_exclusive", 128'(both_err), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
